// File: rtl/counter_sequencer.sv
// Sequencer for one external up/down counter: drives its rst/select from
// registered state and watches its count to produce triangle or sawtooth runs.
// Optional feature: define COUNTER_SEQ_WATCHDOG_EN to add a shadow model of the
// counter that flags divergence on err and aborts the run.
module counter_sequencer #(
  parameter int unsigned BITS  = 4,
  parameter int unsigned CYC_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [BITS-1:0]  top_i,
  input  logic [CYC_W-1:0] cycles_i,
  input  logic [BITS-1:0]  cnt_count,
  output logic             cnt_rst,
  output logic             cnt_select,
  output logic             busy,
  output logic             done,
  output logic [CYC_W-1:0] period_cnt,
  output logic             err
);

  localparam logic [BITS-1:0]  CntOne = BITS'(1);
  localparam logic [CYC_W-1:0] CycOne = CYC_W'(1);

  typedef enum logic [1:0] {StIdle, StUp, StDown, StClr} state_e;

  state_e             state_q, state_d;
  logic               mode_q;
  logic [BITS-1:0]    top_q;
  logic [CYC_W-1:0]   cycles_q;
  logic [CYC_W-1:0]   period_q, period_d;
  logic               done_d;
  logic               err_q, err_d;
  logic               accept;
  logic               end_period;
  logic               wd_trip;

`ifdef COUNTER_SEQ_WATCHDOG_EN
  logic [BITS-1:0] shadow_q, shadow_d;

  // Shadow copy of the counter, stepped by the same registered controls it sees.
  always_comb begin
    shadow_d = shadow_q;
    if (cnt_rst)         shadow_d = '0;
    else if (cnt_select) shadow_d = shadow_q + CntOne;
    else                 shadow_d = shadow_q - CntOne;
  end

  // Shadow register update.
  always_ff @(posedge clk) begin
    if (rst) shadow_q <= '0;
    else     shadow_q <= shadow_d;
  end

  assign wd_trip = busy && (cnt_count != shadow_q);
`else
  assign wd_trip = 1'b0;
`endif

  // Next-state, period counting and abort priority (stop over watchdog over normal flow).
  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    done_d     = 1'b0;
    err_d      = err_q;
    end_period = 1'b0;
    accept     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !stop && (top_i != '0)) begin
          accept   = 1'b1;
          state_d  = StUp;
          period_d = '0;
          err_d    = 1'b0;
        end
      end
      // Turn around one count early so the counter peaks exactly at top.
      StUp: begin
        if (cnt_count == top_q - CntOne) state_d = mode_q ? StClr : StDown;
      end
      StDown: begin
        if (cnt_count == CntOne) end_period = 1'b1;
      end
      StClr: end_period = 1'b1;
      default: state_d = StIdle;
    endcase

    if (end_period) begin
      period_d = period_q + CycOne;
      if ((cycles_q != '0) && (period_d == cycles_q)) begin
        state_d = StIdle;
        done_d  = 1'b1;
      end else begin
        state_d = StUp;
      end
    end

    if (wd_trip) begin
      state_d  = StIdle;
      done_d   = 1'b0;
      period_d = period_q;
      err_d    = 1'b1;
    end

    if (stop && (state_q != StIdle)) begin
      state_d  = StIdle;
      done_d   = 1'b0;
      period_d = period_q;
    end
  end

  // State, latched run parameters and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      mode_q     <= 1'b0;
      top_q      <= '0;
      cycles_q   <= '0;
      period_q   <= '0;
      err_q      <= 1'b0;
      done       <= 1'b0;
      cnt_rst    <= 1'b1;
      cnt_select <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      err_q      <= err_d;
      done       <= done_d;
      cnt_rst    <= (state_d == StIdle) || (state_d == StClr);
      cnt_select <= (state_d == StUp);
      busy       <= (state_d != StIdle);
      if (accept) begin
        mode_q   <= mode;
        top_q    <= top_i;
        cycles_q <= cycles_i;
      end
    end
  end

  assign period_cnt = period_q;
  assign err        = err_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: behavioural counter plus a run-position model.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] top_i = 4'd0;
  logic [3:0] cycles_i = 4'd0;
  logic [3:0] cnt_count;
  logic       cnt_rst, cnt_select, busy, done, err;
  logic [3:0] period_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  counter_sequencer #(.BITS(4), .CYC_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .top_i      (top_i),
    .cycles_i   (cycles_i),
    .cnt_count  (cnt_count),
    .cnt_rst    (cnt_rst),
    .cnt_select (cnt_select),
    .busy       (busy),
    .done       (done),
    .period_cnt (period_cnt),
    .err        (err)
  );

  always #5 clk = ~clk;

  // The controlled counter, with an override used to inject a divergence.
  logic [3:0] cnt_q = 4'd0;
  logic       force_en = 1'b0;
  logic [3:0] force_val = 4'd0;
  always @(posedge clk) cnt_q <= cnt_rst ? 4'd0 : (cnt_select ? cnt_q + 4'd1 : cnt_q - 4'd1);
  assign cnt_count = force_en ? force_val : cnt_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: a run is a position index into a repeating period of length plen.
  bit m_active = 0;
  bit m_mode = 0;
  bit m_done = 0;
  int m_top = 1, m_cycles = 0, m_idx = 0, m_plen = 1, idle_age = 0;
  bit chk_en = 0;

  always @(posedge clk) begin
    m_done = 0;
    if (rst) begin
      m_active = 0;
      m_idx    = 0;
      m_plen   = 1;
    end else if (m_active) begin
      if (stop) m_active = 0;
      else begin
        m_idx++;
        if (m_cycles != 0 && m_idx == m_cycles * m_plen) begin
          m_active = 0;
          m_done   = 1;
        end
      end
    end else if (start && !stop && top_i != 0) begin
      m_active = 1;
      m_mode   = mode;
      m_top    = int'(top_i);
      m_cycles = int'(cycles_i);
      m_idx    = 0;
      m_plen   = mode ? m_top + 1 : 2 * m_top;
    end
    if (m_active) idle_age = 0;
    else if (idle_age < 100) idle_age++;
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      int pos, ecnt;
      check("busy", busy, m_active);
      check("done", done, m_done);
      check("period_cnt", period_cnt, (m_idx / m_plen) % 16);
      check("err", err, 0);
      if (m_active) begin
        pos  = m_idx % m_plen;
        ecnt = (pos <= m_top) ? pos : 2 * m_top - pos;
        check("count", cnt_count, ecnt);
        check("select", cnt_select, pos < m_top);
        check("cnt_rst", cnt_rst, m_mode && pos == m_top);
      end else begin
        check("idle_cnt_rst", cnt_rst, 1);
        check("idle_select", cnt_select, 0);
        if (idle_age >= 2) check("idle_count", cnt_count, 0);
      end
    end
  end

  logic [3:0] tr_cnt [16];
  logic       tr_rst [16];

  task automatic do_start(input logic m, input logic [3:0] t, input logic [3:0] c);
    mode = m; top_i = t; cycles_i = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Record the run until busy drops; at index poke_at issue an ignored start.
  task automatic capture(input int poke_at, output int n);
    n = 0;
    while (busy && n < 64) begin
      if (n < 16) begin
        tr_cnt[n] = cnt_count;
        tr_rst[n] = cnt_rst;
      end
      if (n == poke_at) begin
        start = 1'b1; mode = 1'b1; top_i = 4'd7; cycles_i = 4'd0;
      end else start = 1'b0;
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    if (busy) check("capture_bound", busy, 0);
  endtask

  initial begin
    int n, g;
    int exp1 [12] = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1};
    int exp4 [4]  = '{0, 1, 2, 1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_cnt_rst", cnt_rst, 1);
    check("rst_select", cnt_select, 0);
    check("rst_done", done, 0);
    check("rst_period", period_cnt, 0);
    check("rst_err", err, 0);
    chk_en = 1;
    @(negedge clk);

    // T1 triangle top=3 cycles=2
    do_start(1'b0, 4'd3, 4'd2);
    capture(-1, n);
    check("t1_len", n, 12);
    for (int i = 0; i < 12; i++) check($sformatf("t1_cnt%0d", i), tr_cnt[i], exp1[i]);
    check("t1_done", done, 1);
    check("t1_count_end", cnt_count, 0);
    check("t1_period", period_cnt, 2);
    @(negedge clk);
    check("t1_done_pulse", done, 0);

    // T2 sawtooth top=3 cycles=3
    do_start(1'b1, 4'd3, 4'd3);
    capture(-1, n);
    check("t2_len", n, 12);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("t2_cnt%0d", i), tr_cnt[i], i % 4);
      check($sformatf("t2_rst%0d", i), tr_rst[i], (i % 4) == 3);
    end
    check("t2_done", done, 1);
    check("t2_period", period_cnt, 3);
    @(negedge clk);

    // T3 triangle top=5 endless, stopped at first descending 4
    do_start(1'b0, 4'd5, 4'd0);
    g = 0;
    while (!(cnt_count == 4'd4 && !cnt_select) && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) check("t3_bound", g, 0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("t3_busy", busy, 0);
    check("t3_cnt_rst", cnt_rst, 1);
    check("t3_done", done, 0);
    @(negedge clk);
    check("t3_count", cnt_count, 0);
    check("t3_done2", done, 0);
    check("t3_period", period_cnt, 0);

    // T4 edge cases
    mode = 1'b0; top_i = 4'd0; cycles_i = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t4_top0_busy", busy, 0);
    top_i = 4'd3; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("t4_startstop_busy", busy, 0);
    @(negedge clk);
    do_start(1'b0, 4'd2, 4'd1);
    capture(1, n);
    check("t4_busy_start_len", n, 4);
    for (int i = 0; i < 4; i++) check($sformatf("t4_cnt%0d", i), tr_cnt[i], exp4[i]);
    check("t4_busy_start_period", period_cnt, 1);
    @(negedge clk);
    do_start(1'b0, 4'd1, 4'd2);
    capture(-1, n);
    check("t4_top1_len", n, 4);
    for (int i = 0; i < 4; i++) check($sformatf("t4_top1_cnt%0d", i), tr_cnt[i], i % 2);
    check("t4_top1_done", done, 1);
    @(negedge clk);

    // T5 rst mid-run, then a fresh run
    do_start(1'b1, 4'd7, 4'd0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_cnt_rst", cnt_rst, 1);
    check("t5_select", cnt_select, 0);
    check("t5_done", done, 0);
    check("t5_period", period_cnt, 0);
    @(negedge clk);
    do_start(1'b0, 4'd2, 4'd1);
    capture(-1, n);
    check("t5_len", n, 4);
    for (int i = 0; i < 4; i++) check($sformatf("t5_cnt%0d", i), tr_cnt[i], exp4[i]);
    @(negedge clk);

`ifdef COUNTER_SEQ_WATCHDOG_EN
    // T6 injected divergence
    chk_en = 0;
    do_start(1'b0, 4'd5, 4'd0);
    repeat (2) @(negedge clk);
    force_en = 1'b1; force_val = 4'd6;
    @(negedge clk);
    force_en = 1'b0;
    check("t6_err", err, 1);
    check("t6_done", done, 0);
    @(negedge clk);
    check("t6_busy", busy, 0);
    check("t6_done2", done, 0);
    repeat (3) @(negedge clk);
    check("t6_err_sticky", err, 1);
    do_start(1'b0, 4'd2, 4'd1);
    check("t6_err_clear", err, 0);
    capture(-1, n);
    check("t6_rerun_len", n, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
